riscv_register_file: RTL



---
 rtl/riscv_register_file.sv | 101 ++++++++++
 1 files changed

// File: rtl/riscv_register_file.sv
`default_nettype none
// ============================================================================
// Module   : riscv_register_file
// Brief    : RV32I 32 x XLEN register file, two combinational read ports,
//            one synchronous write port, built-in post-reset clear sequencer.
//            Optional same-cycle write->read forwarding: REGFILE_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
module riscv_register_file #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] register_write_select,
    input  logic [XLEN-1:0]   register_data_write,
    output logic [XLEN-1:0]   register_data_1,
    output logic [XLEN-1:0]   register_data_2,
    output logic              ready
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] c_last_idx = (ADDR_W + 1)'(REG_COUNT - 1);

    state_t            r_state;
    logic [ADDR_W:0]   r_clr_idx;
    logic              r_ready;
    logic [XLEN-1:0]   r_regs [REG_COUNT];

    logic              w_wr_valid;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;

    assign w_wr_valid = write_enable && (register_write_select != '0);

    // Array contents are deliberately left untouched while reset is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_regs[r_clr_idx[ADDR_W-1:0]] <= '0;
                    r_clr_idx                     <= r_clr_idx + 1'b1;
                    if (r_clr_idx == c_last_idx) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_wr_valid) begin
                        r_regs[register_write_select] <= register_data_write;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (r_state == ST_READY) begin
            if (rs1 != '0) begin
                w_rd1 = r_regs[rs1];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_valid && (register_write_select == rs1)) begin
                    w_rd1 = register_data_write;
                end
`endif
            end
            if (rs2 != '0) begin
                w_rd2 = r_regs[rs2];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_valid && (register_write_select == rs2)) begin
                    w_rd2 = register_data_write;
                end
`endif
            end
        end
    end

    assign register_data_1 = w_rd1;
    assign register_data_2 = w_rd2;
    assign ready           = r_ready;

endmodule
`default_nettype wire
